mem_req_sequencer: RTL and testbench

// - Upstream request front-end for the cache+RAM memory controller.
// - Accepts read/write requests on a valid/ready interface and buffers them in a FIFO.
// - Issues each request to the controller as a single-cycle addr/data/wr_en command.
// - For reads, waits a fixed latency and returns the captured data on a valid/ready response port.
//

---
 rtl/mem_seq_pkg.sv | 21 ++
 rtl/mem_req_sequencer_if.sv | 31 +++
 rtl/mem_req_sequencer_fifo.sv | 55 +++++
 rtl/mem_req_sequencer.sv | 143 ++++++++++++++
 tb/tb_mem_req_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types for the memory request sequencer: FSM state encoding and the
// request payload carried through the request FIFO.
package mem_seq_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
    } mem_req_t;

endpackage

// File: rtl/mem_req_sequencer_if.sv
// Request, response and controller-command signals of the memory request sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface mem_req_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_we;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, rsp_ready, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_data_in, mem_wr_en
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, rsp_ready, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_data_in, mem_wr_en
    );
endinterface

// File: rtl/mem_req_sequencer_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate occupancy counter.
module mem_req_fifo
    import mem_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  mem_req_t wr_req,
    output mem_req_t rd_req_c,
    output logic     full_c,
    output logic     empty_c
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    mem_req_t         mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign rd_req_c = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_req;
    end

endmodule

// File: rtl/mem_req_sequencer.sv
// Memory request sequencer: buffers requests, issues one command at a time to
// the controller and returns read data. MEM_SEQ_WRITE_ACK_EN adds a zero-data
// response for every write.
module mem_req_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W,
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_req_sequencer_if.slave    bus,
    output logic                  busy
);
    localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    seq_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
    logic [DATA_WIDTH-1:0] iss_data_q, iss_data_d;
    logic                  iss_we_q, iss_we_d;
    logic                  wr_en_q, wr_en_d;
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;

    mem_req_t fifo_wr;
    mem_req_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     pop_c;

    assign fifo_wr = '{addr:  ADDR_W'(bus.req_addr),
                       wdata: DATA_W'(bus.req_wdata),
                       we:    bus.req_we};
    assign pop_c   = (state_q == IDLE) && !fifo_empty;

    mem_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.req_valid),
        .pop      (pop_c),
        .wr_req   (fifo_wr),
        .rd_req_c (fifo_head),
        .full_c   (fifo_full),
        .empty_c  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!fifo_empty) state_d = ISSUE;
            ISSUE: begin
                if (!iss_we_q) state_d = WAIT;
`ifdef MEM_SEQ_WRITE_ACK_EN
                else           state_d = RESP;
`else
                else           state_d = IDLE;
`endif
            end
            WAIT:  if (lat_cnt_q == '0) state_d = RESP;
            RESP:  if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the issue, latency and response registers.
    always_comb begin
        iss_addr_d  = iss_addr_q;
        iss_data_d  = iss_data_q;
        iss_we_d    = iss_we_q;
        wr_en_d     = 1'b0;
        lat_cnt_d   = lat_cnt_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    iss_addr_d = ADDR_WIDTH'(fifo_head.addr);
                    iss_data_d = DATA_WIDTH'(fifo_head.wdata);
                    iss_we_d   = fifo_head.we;
                    wr_en_d    = fifo_head.we;
                end
            end
            ISSUE: begin
                if (!iss_we_q) lat_cnt_d = LAT_W'(RD_LATENCY - 1);
`ifdef MEM_SEQ_WRITE_ACK_EN
                else begin
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                end
`endif
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    rdata_d     = DATA_WIDTH'(bus.mem_data_out);
                    rsp_valid_d = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: rsp_valid_d = !bus.rsp_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_addr_q  <= '0;
            iss_data_q  <= '0;
            iss_we_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            lat_cnt_q   <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            iss_addr_q  <= iss_addr_d;
            iss_data_q  <= iss_data_d;
            iss_we_q    <= iss_we_d;
            wr_en_q     <= wr_en_d;
            lat_cnt_q   <= lat_cnt_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready   = !fifo_full;
    assign bus.mem_addr    = iss_addr_q;
    assign bus.mem_data_in = iss_data_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign busy            = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed and randomized checks of mem_req_sequencer against an in-order
// request model and a one-cycle-latency controller memory.
module tb_mem_req_sequencer;

    localparam int unsigned L = 1;
`ifdef MEM_SEQ_WRITE_ACK_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif

    typedef struct { logic we; logic [31:0] addr; logic [7:0] data; } req_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_ev_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    req_t       req_q[$];
    wr_ev_t     wr_log[$];
    logic [7:0] rsp_log[$];
    bit   [7:0] ctl_mem [256];
    bit   [7:0] ref_mem [256];
    int         wr_base  = 0;
    int         rsp_base = 0;

    mem_req_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus ();

    mem_req_sequencer #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4),
        .RD_LATENCY (L)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Controller stand-in: writes land on the issue edge, read data follows one cycle later.
    always @(posedge clk) begin
        if (bus.mem_wr_en) ctl_mem[bus.mem_addr[7:0]] <= bus.mem_data_in;
        bus.mem_data_out <= ctl_mem[bus.mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (rst && bus.mem_wr_en)
            wr_log.push_back('{addr: bus.mem_addr, data: bus.mem_data_in});
        if (rst && bus.rsp_valid && bus.rsp_ready)
            rsp_log.push_back(bus.rsp_rdata);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic set_req(input logic we, input logic [31:0] a, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.we   = 1'($urandom_range(0, 1));
        r.addr = 32'($urandom_range(0, 15));
        r.data = 8'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic push_wait(input req_t r);
        bit done = 1'b0;
        set_req(r.we, r.addr, r.data);
        for (int c = 0; c < 100 && !done; c++) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
            if (bus.req_ready) begin
                req_q.push_back(r);
                done = 1'b1;
            end
            tick();
        end
        bus.req_valid = 1'b0;
        check("push_accept", 64'(done), 64'(1));
    endtask

    // Drain, then compare the observed command and response streams with the
    // requests applied one at a time, in order, to a reference memory.
    task automatic verify_batch(input string tag);
        int n_wr  = 0;
        int n_rsp = 0;
        int wi;
        int ri;
        foreach (req_q[i]) begin
            if (req_q[i].we) begin
                n_wr++;
                if (ACK) n_rsp++;
            end else begin
                n_rsp++;
            end
        end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (wr_log.size() >= wr_base + n_wr && rsp_log.size() >= rsp_base + n_rsp && !busy)
                break;
            tick();
        end
        repeat (4) tick();
        check({tag, "_idle"},    64'(busy), 64'(0));
        check({tag, "_wr_cnt"},  64'(wr_log.size() - wr_base), 64'(n_wr));
        check({tag, "_rsp_cnt"}, 64'(rsp_log.size() - rsp_base), 64'(n_rsp));
        wi = wr_base;
        ri = rsp_base;
        foreach (req_q[i]) begin
            if (req_q[i].we) begin
                if (wi < wr_log.size()) begin
                    check({tag, "_wr_addr"}, 64'(wr_log[wi].addr), 64'(req_q[i].addr));
                    check({tag, "_wr_data"}, 64'(wr_log[wi].data), 64'(req_q[i].data));
                end
                wi++;
                ref_mem[req_q[i].addr[7:0]] = req_q[i].data;
`ifdef MEM_SEQ_WRITE_ACK_EN
                if (ri < rsp_log.size()) check({tag, "_ack_data"}, 64'(rsp_log[ri]), 64'(0));
                ri++;
`endif
            end else begin
                if (ri < rsp_log.size())
                    check({tag, "_rd_data"}, 64'(rsp_log[ri]), 64'(ref_mem[req_q[i].addr[7:0]]));
                ri++;
            end
        end
        wr_base  = wr_log.size();
        rsp_base = rsp_log.size();
        req_q.delete();
    endtask

    initial begin
        req_t r;
        int   n_wr;
        int   n_rsp;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b0;

        // Reset values, both while held and just after release.
        repeat (3) tick();
        check("rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_wr_en",     64'(bus.mem_wr_en), 64'(0));
        check("rst_busy",      64'(busy),          64'(0));
        check("rst_mem_addr",  64'(bus.mem_addr),  64'(0));
        rst = 1'b1;
        tick();
        check("rel_req_ready", 64'(bus.req_ready), 64'(1));
        check("rel_busy",      64'(busy),          64'(0));
        check("rel_wr_en",     64'(bus.mem_wr_en), 64'(0));

        // Single write: one-cycle command pulse two edges after the push.
        bus.rsp_ready = 1'b1;
        set_req(1'b1, 32'h10, 8'hA5);
        req_q.push_back('{we: 1'b1, addr: 32'h10, data: 8'hA5});
        tick();
        bus.req_valid = 1'b0;
        check("wr_busy",       64'(busy),            64'(1));
        check("wr_pre_en",     64'(bus.mem_wr_en),   64'(0));
        tick();
        check("wr_issue_en",   64'(bus.mem_wr_en),   64'(1));
        check("wr_issue_addr", 64'(bus.mem_addr),    64'(32'h10));
        check("wr_issue_data", 64'(bus.mem_data_in), 64'(8'hA5));
        tick();
        check("wr_post_en",    64'(bus.mem_wr_en),   64'(0));
        check("wr_hold_addr",  64'(bus.mem_addr),    64'(32'h10));
        check("wr_rsp_valid",  64'(bus.rsp_valid),   64'(ACK));
        verify_batch("wr1");

        // Read of the same address: response three cycles after the pop, then held.
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 32'h10, 8'h00);
        req_q.push_back('{we: 1'b0, addr: 32'h10, data: 8'h00});
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("rd_issue_en",   64'(bus.mem_wr_en), 64'(0));
        check("rd_issue_addr", 64'(bus.mem_addr),  64'(32'h10));
        tick();
        check("rd_wait_valid", 64'(bus.rsp_valid), 64'(0));
        tick();
        check("rd_rsp_valid",  64'(bus.rsp_valid), 64'(1));
        check("rd_rsp_data",   64'(bus.rsp_rdata), 64'(8'hA5));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rd_hold_valid", 64'(bus.rsp_valid), 64'(1));
            check("rd_hold_data",  64'(bus.rsp_rdata), 64'(8'hA5));
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("rd_release", 64'(bus.rsp_valid), 64'(0));
        verify_batch("rd1");

        // Fill: a stalled read holds the FSM in RESP while four more requests fill the FIFO.
        bus.rsp_ready = 1'b0;
        r = rand_req();
        r.we = 1'b0;
        set_req(r.we, r.addr, r.data);
        req_q.push_back(r);
        tick();
        bus.req_valid = 1'b0;
        repeat (3) tick();
        check("fill_stall_valid", 64'(bus.rsp_valid), 64'(1));
        for (int i = 0; i < 4; i++) begin
            r = rand_req();
            set_req(r.we, r.addr, r.data);
            check("fill_ready", 64'(bus.req_ready), 64'(1));
            req_q.push_back(r);
            tick();
        end
        check("fill_full", 64'(bus.req_ready), 64'(0));
        set_req(1'b1, 32'hFF, 8'hEE);
        repeat (3) begin
            tick();
            check("fill_blocked", 64'(bus.req_ready), 64'(0));
        end
        check("fill_busy", 64'(busy), 64'(1));
        bus.rsp_ready = 1'b1;
        tick();
        check("fill_still_full", 64'(bus.req_ready), 64'(0));
        tick();
        check("fill_no_bypass", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b0;
        verify_batch("fill");

        // Reset while a read waits on the controller with two requests queued behind it.
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 32'h3, 8'h00);
        tick();
        set_req(1'b1, 32'h4, 8'h44);
        tick();
        set_req(1'b1, 32'h5, 8'h55);
        tick();
        bus.req_valid = 1'b0;
        n_wr  = wr_log.size();
        n_rsp = rsp_log.size();
        rst = 1'b0;
        #1;
        check("mid_rst_wr_en",     64'(bus.mem_wr_en), 64'(0));
        check("mid_rst_busy",      64'(busy),          64'(0));
        check("mid_rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("mid_rst_mem_addr",  64'(bus.mem_addr),  64'(0));
        tick();
        tick();
        rst = 1'b1;
        repeat (10) tick();
        check("post_rst_no_wr",  64'(wr_log.size()),  64'(n_wr));
        check("post_rst_no_rsp", 64'(rsp_log.size()), 64'(n_rsp));
        check("post_rst_busy",   64'(busy),           64'(0));

        // Write followed immediately by a read of the same address.
        set_req(1'b1, 32'h20, 8'h5A);
        req_q.push_back('{we: 1'b1, addr: 32'h20, data: 8'h5A});
        tick();
        set_req(1'b0, 32'h20, 8'h00);
        req_q.push_back('{we: 1'b0, addr: 32'h20, data: 8'h00});
        tick();
        bus.req_valid = 1'b0;
        verify_batch("wr_rd");

        // Random traffic with random gaps and response back-pressure.
        for (int n = 0; n < 40; n++) begin
            r = rand_req();
            repeat ($urandom_range(0, 2)) begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
                tick();
            end
            push_wait(r);
        end
        verify_batch("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
